// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-wide memory arbiter.
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_rr).
package mem_arb_pkg;

    typedef enum logic [2:0] {
        PRIME1   = 3'd0,
        PRIME2   = 3'd1,
        IDLE     = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        WR_ISSUE = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // D is id 0 so the reset value of the pointer favours D
    localparam logic PORT_D = 1'b0;
    localparam logic PORT_F = 1'b1;

    localparam int PRIME_ADDR1 = 1;
    localparam int PRIME_ADDR2 = 2;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        unique case (size)
            SIZE_BYTE:        n = 3'd1;
            SIZE_HALF:        n = 3'd2;
            SIZE_WORD, 2'd3:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester grant logic with a tie-break pointer.
// MEM_ARB_RR_EN: pointer flips to the loser; otherwise pinned to D.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic f_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_port
);

    logic rr_ptr;
    logic rr_next;

    assign grant_valid = f_req | d_req;

    always_comb begin
        grant_port = rr_ptr;
        if (f_req != d_req) begin
            grant_port = d_req ? PORT_D : PORT_F;
        end
    end

`ifdef MEM_ARB_RR_EN
    assign rr_next = (grant_en && grant_valid) ? ~grant_port : rr_ptr;
`else
    assign rr_next = grant_en ? PORT_D : rr_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a byte-wide memory between fetch (F) and load/store (D) ports.
// Define MEM_ARB_RR_EN for round-robin; default is fixed D-over-F priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic [1:0]    f_size,
    output logic [DW-1:0] f_rdata,
    output logic          f_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_size,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data_in,
    input  logic [7:0]    mem_data_out,
    output logic          mem_read_en,
    output logic          mem_write_en,
    input  logic          mem_ready
);
    import mem_arb_pkg::*;

    state_t        state, nstate;
    logic          prime_wait, n_prime_wait;
    logic [AW-1:0] shadow_addr, n_shadow_addr;
    logic          shadow_valid, n_shadow_valid;
    logic          req_port, n_req_port;
    logic          req_we, n_req_we;
    logic [AW-1:0] req_addr, n_req_addr;
    logic [DW-1:0] req_wdata, n_req_wdata;
    logic [2:0]    byte_cnt, n_byte_cnt;
    logic [1:0]    byte_idx, n_byte_idx;
    logic [DW-1:0] rdata_q, n_rdata_q;

    logic          grant_en, grant_valid, grant_port;
    logic [AW-1:0] byte_addr, addr_c;
    logic [4:0]    lane;
    logic          last_byte;
    logic [7:0]    din_c;
    logic          rd_c, wr_c, f_ack_c, d_ack_c;

    mem_arb_rr u_rr (
        .clk         (clk),
        .rst         (rst),
        .f_req       (f_req),
        .d_req       (d_req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign byte_addr = req_addr + AW'(byte_idx);
    assign lane      = {byte_idx, 3'b000};
    assign last_byte = ({1'b0, byte_idx} == byte_cnt - 3'd1);

    always_comb begin
        nstate         = state;
        n_prime_wait   = prime_wait;
        n_shadow_addr  = shadow_addr;
        n_shadow_valid = shadow_valid;
        n_req_port     = req_port;
        n_req_we       = req_we;
        n_req_addr     = req_addr;
        n_req_wdata    = req_wdata;
        n_byte_cnt     = byte_cnt;
        n_byte_idx     = byte_idx;
        n_rdata_q      = rdata_q;
        grant_en       = 1'b0;
        addr_c         = '0;
        din_c          = '0;
        rd_c           = 1'b0;
        wr_c           = 1'b0;
        f_ack_c        = 1'b0;
        d_ack_c        = 1'b0;

        unique case (state)
            PRIME1, PRIME2: begin
                // memory has no reset: two dummy reads pin its last address to 2
                n_prime_wait = ~prime_wait;
                if (!prime_wait) begin
                    addr_c = (state == PRIME1) ? AW'(PRIME_ADDR1) : AW'(PRIME_ADDR2);
                    rd_c   = 1'b1;
                end else if (state == PRIME1) begin
                    nstate = PRIME2;
                end else begin
                    nstate         = IDLE;
                    n_shadow_addr  = AW'(PRIME_ADDR2);
                    n_shadow_valid = 1'b1;
                end
            end
            IDLE: begin
                grant_en = 1'b1;
                if (grant_valid) begin
                    n_req_port  = grant_port;
                    n_req_we    = (grant_port == PORT_D) && d_we;
                    n_req_addr  = (grant_port == PORT_D) ? d_addr : f_addr;
                    n_byte_cnt  = size_bytes((grant_port == PORT_D) ? d_size : f_size);
                    n_req_wdata = d_wdata;
                    n_byte_idx  = 2'd0;
                    n_rdata_q   = '0;
                    nstate      = n_req_we ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (shadow_valid && byte_addr == shadow_addr) begin
                    n_rdata_q[lane +: 8] = mem_data_out;
                    n_byte_idx           = byte_idx + 2'd1;
                    nstate               = last_byte ? DONE : RD_ISSUE;
                end else begin
                    addr_c = byte_addr;
                    rd_c   = 1'b1;
                    nstate = RD_WAIT;
                end
            end
            RD_WAIT: begin
                nstate = RD_ISSUE;
                if (mem_ready) begin
                    n_rdata_q[lane +: 8] = mem_data_out;
                    n_shadow_addr        = byte_addr;
                    n_shadow_valid       = 1'b1;
                    n_byte_idx           = byte_idx + 2'd1;
                    nstate               = last_byte ? DONE : RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                addr_c         = byte_addr;
                din_c          = req_wdata[lane +: 8];
                wr_c           = 1'b1;
                n_shadow_valid = 1'b0;
                n_byte_idx     = byte_idx + 2'd1;
                nstate         = last_byte ? DONE : WR_ISSUE;
            end
            DONE: begin
                f_ack_c = (req_port == PORT_F);
                d_ack_c = (req_port == PORT_D);
                nstate  = IDLE;
            end
            default: nstate = PRIME1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PRIME1;
            prime_wait   <= 1'b0;
            shadow_addr  <= '0;
            shadow_valid <= 1'b0;
            req_port     <= 1'b0;
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            byte_cnt     <= 3'd0;
            byte_idx     <= 2'd0;
            rdata_q      <= '0;
        end else begin
            state        <= nstate;
            prime_wait   <= n_prime_wait;
            shadow_addr  <= n_shadow_addr;
            shadow_valid <= n_shadow_valid;
            req_port     <= n_req_port;
            req_we       <= n_req_we;
            req_addr     <= n_req_addr;
            req_wdata    <= n_req_wdata;
            byte_cnt     <= n_byte_cnt;
            byte_idx     <= n_byte_idx;
            rdata_q      <= n_rdata_q;
        end
    end

    // outputs forced low while rst is high, even though the FSM sits in PRIME1
    assign mem_addr     = rst ? '0 : addr_c;
    assign mem_data_in  = rst ? '0 : din_c;
    assign mem_read_en  = !rst && rd_c;
    assign mem_write_en = !rst && wr_c;
    assign f_ack        = !rst && f_ack_c;
    assign d_ack        = !rst && d_ack_c;
    assign f_rdata      = f_ack ? rdata_q : '0;
    assign d_rdata      = d_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a quirky byte-memory model.
// Expected grant order follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic [1:0]  f_size = '0;
    logic [31:0] f_rdata;
    logic        f_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out = 8'h00;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        mem_ready = 1'b0;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_size       (f_size),
        .f_rdata      (f_rdata),
        .f_ack        (f_ack),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_size       (d_size),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } acc_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    acc_t rd_log[$];
    acc_t wr_log[$];
    ack_t acks[$];
    ack_t exp_q[$];

    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rdm(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    logic        s_re = 1'b0;
    logic        s_we = 1'b0;
    logic [31:0] s_addr = '0;
    logic [7:0]  s_din = '0;
    logic [31:0] last_addr = 32'd1;
    logic        last_v = 1'b1;

    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (s_re) begin
            mem_ready    <= !(last_v && last_addr == s_addr);
            mem_data_out <= rdm(s_addr);
            last_addr    <= s_addr;
            last_v       <= 1'b1;
        end else if (s_we) begin
            mem[s_addr] = s_din;
            last_v <= 1'b0;
        end
    end

    int   prime_left = 0;
    logic pend_rd = 1'b0;
    logic pend_prime = 1'b0;
    int   prot_err = 0;
    int   both_err = 0;

    always @(negedge clk) begin
        s_re   = mem_read_en;
        s_we   = mem_write_en;
        s_addr = mem_addr;
        s_din  = mem_data_in;
        if (pend_rd && !pend_prime && !mem_ready) prot_err++;
        pend_rd    = mem_read_en;
        pend_prime = 1'b0;
        if (rst) begin
            prime_left = 2;
        end else if (mem_read_en && prime_left > 0) begin
            pend_prime = 1'b1;
            prime_left--;
        end
        if (mem_read_en && mem_write_en) both_err++;
        if (mem_read_en) rd_log.push_back('{mem_addr, 8'h00, cyc});
        if (mem_write_en) wr_log.push_back('{mem_addr, mem_data_in, cyc});
        if (f_ack) acks.push_back('{1'b0, f_rdata, cyc});
        if (d_ack) acks.push_back('{1'b1, d_rdata, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (acks.size() > 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // port: 1 = D, 0 = F; c0 is the cycle the request is first visible
    task automatic run_req(input bit port, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           output bit got, output ack_t obs, output int c0);
        c0 = cyc;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr; f_size = size;
        end
        wait_ack(80, got);
        f_req = 1'b0;
        d_req = 1'b0;
        obs = '{1'b0, 32'h0, 0};
        if (got) obs = acks.pop_front();
    endtask

    int r0;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({f_ack, d_ack, mem_read_en, mem_write_en, mem_addr, mem_data_in, f_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h acks=%b%b required all zero",
                     mem_read_en, mem_write_en, mem_addr, f_ack, d_ack);
        end
        rd_log.delete(); wr_log.delete(); acks.delete();
        rst = 1'b0;
        r0 = cyc;
        repeat (4) tick();
        checks++;
        if (rd_log.size() != 2) begin
            errors++;
            $display("FAIL prime_reads: got %0d reads required 2", rd_log.size());
        end else begin
            checks++;
            if (rd_log[0].addr !== 32'd1 || rd_log[0].cyc != r0) begin
                errors++;
                $display("FAIL prime1: got addr %h cyc %0d required 1 cyc %0d",
                         rd_log[0].addr, rd_log[0].cyc, r0);
            end
            checks++;
            if (rd_log[1].addr !== 32'd2 || rd_log[1].cyc != r0 + 2) begin
                errors++;
                $display("FAIL prime2: got addr %h cyc %0d required 2 cyc %0d",
                         rd_log[1].addr, rd_log[1].cyc, r0 + 2);
            end
        end
        checks++;
        if (wr_log.size() != 0 || acks.size() != 0) begin
            errors++;
            $display("FAIL prime_quiet: got %0d writes %0d acks required 0 0", wr_log.size(), acks.size());
        end
    endtask

    task automatic test_write_read();
        bit got; ack_t a, e; int c0;
        logic [31:0] w;
        w = 32'hDEADBEEF;
        exp_q.push_back('{1'b1, 32'h0, 0});
        rd_log.delete(); wr_log.delete();
        run_req(1'b1, 1'b1, 32'h10, 2'd2, w, got, a, c0);
        e = exp_q.pop_front();
        checks++;
        if (!got || a.port !== e.port || a.cyc != c0 + 5) begin
            errors++;
            $display("FAIL write_ack: got ok=%b port=%b cyc=%0d required port=%b cyc=%0d",
                     got, a.port, a.cyc, e.port, c0 + 5);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_log.size() != 4) begin
                errors++;
                $display("FAIL write_count: got %0d writes required 4", wr_log.size());
                break;
            end
            if (wr_log[k].addr !== 32'h10 + k || wr_log[k].data !== w[8*k +: 8]) begin
                errors++;
                $display("FAIL write_byte%0d: got %h@%h required %h@%h", k,
                         wr_log[k].data, wr_log[k].addr, w[8*k +: 8], 32'h10 + k);
            end
        end
        exp_q.push_back('{1'b1, 32'hDEADBEEF, 9});
        run_req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0, got, a, c0);
        e = exp_q.pop_front();
        checks++;
        if (!got || a.port !== e.port || a.rdata !== e.rdata || a.cyc != c0 + e.cyc) begin
            errors++;
            $display("FAIL word_read: got ok=%b data=%h cyc=%0d required %h cyc %0d",
                     got, a.rdata, a.cyc, e.rdata, c0 + e.cyc);
        end
    endtask

    task automatic test_shadow_hit();
        bit got; ack_t a, e; int c0, n;
        exp_q.push_back('{1'b0, 32'h000000DE, 0});
        exp_q.push_back('{1'b0, 32'h000000DE, 2});
        run_req(1'b0, 1'b0, 32'h13, 2'd0, 32'h0, got, a, c0);
        e = exp_q.pop_front();
        checks++;
        if (!got || a.port !== e.port || a.rdata !== e.rdata) begin
            errors++;
            $display("FAIL byte_read1: got ok=%b port=%b data=%h required %h",
                     got, a.port, a.rdata, e.rdata);
        end
        n = rd_log.size();
        run_req(1'b0, 1'b0, 32'h13, 2'd0, 32'h0, got, a, c0);
        e = exp_q.pop_front();
        checks++;
        if (!got || a.rdata !== e.rdata || a.cyc != c0 + e.cyc) begin
            errors++;
            $display("FAIL byte_hit: got ok=%b data=%h cyc=%0d required %h cyc %0d",
                     got, a.rdata, a.cyc, e.rdata, c0 + e.cyc);
        end
        checks++;
        if (rd_log.size() != n) begin
            errors++;
            $display("FAIL hit_no_read: got %0d reads required 0", rd_log.size() - n);
        end
    endtask

    task automatic test_arbitration();
        ack_t a, e; int d_left, f_left;
`ifdef MEM_ARB_RR_EN
        exp_q.push_back('{1'b1, {24'h0, rdm(32'h10)}, 0});
        exp_q.push_back('{1'b0, {24'h0, rdm(32'h12)}, 0});
        exp_q.push_back('{1'b1, {24'h0, rdm(32'h11)}, 0});
        exp_q.push_back('{1'b0, {24'h0, rdm(32'h13)}, 0});
`else
        exp_q.push_back('{1'b1, {24'h0, rdm(32'h10)}, 0});
        exp_q.push_back('{1'b1, {24'h0, rdm(32'h11)}, 0});
        exp_q.push_back('{1'b0, {24'h0, rdm(32'h12)}, 0});
        exp_q.push_back('{1'b0, {24'h0, rdm(32'h13)}, 0});
`endif
        d_left = 2; f_left = 2;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h10;
        f_req = 1'b1; f_size = 2'd0; f_addr = 32'h12;
        for (int t = 0; t < 200 && (d_left + f_left) > 0; t++) begin
            tick();
            if (acks.size() > 0) begin
                a = acks.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (a.port !== e.port || a.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL grant%0d: got port=%b data=%h required port=%b data=%h",
                             4 - d_left - f_left, a.port, a.rdata, e.port, e.rdata);
                end
                if (a.port) begin
                    d_left--; d_addr = 32'h11;
                    if (d_left <= 0) d_req = 1'b0;
                end else begin
                    f_left--; f_addr = 32'h13;
                    if (f_left <= 0) f_req = 1'b0;
                end
            end
        end
        d_req = 1'b0; f_req = 1'b0;
        exp_q.delete();
        checks++;
        if (d_left + f_left != 0) begin
            errors++;
            $display("FAIL arb_timeout: got %0d outstanding required 0", d_left + f_left);
        end
    endtask

    task automatic test_wrap();
        bit got; ack_t a, e; int c0, n;
        exp_q.push_back('{1'b0, {16'h0, rdm(32'h0), rdm(32'hFFFFFFFF)}, 5});
        n = rd_log.size();
        run_req(1'b0, 1'b0, 32'hFFFFFFFF, 2'd1, 32'h0, got, a, c0);
        e = exp_q.pop_front();
        checks++;
        if (!got || a.rdata !== e.rdata || a.cyc != c0 + e.cyc) begin
            errors++;
            $display("FAIL wrap_half: got ok=%b data=%h cyc=%0d required %h cyc %0d",
                     got, a.rdata, a.cyc, e.rdata, c0 + e.cyc);
        end
        checks++;
        if (rd_log.size() != n + 2) begin
            errors++;
            $display("FAIL wrap_reads: got %0d reads required 2", rd_log.size() - n);
        end else if (rd_log[n].addr !== 32'hFFFFFFFF || rd_log[n+1].addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addrs: got %h,%h required ffffffff,00000000",
                     rd_log[n].addr, rd_log[n+1].addr);
        end
    endtask

    task automatic test_reset_mid_write();
        bit got; ack_t a, e; int c0, r, n;
        logic [7:0] o2, o3;
        o2 = rdm(32'h42); o3 = rdm(32'h43);
        wr_log.delete();
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_size = 2'd2; d_wdata = 32'h11223344;
        while (cyc < c0 + 3) tick();
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        tick();
        rst = 1'b0;
        r = cyc;
        n = rd_log.size();
        repeat (4) tick();
        checks++;
        if (acks.size() != 0) begin
            errors++;
            $display("FAIL abort_no_ack: got %0d acks required 0", acks.size());
            acks.delete();
        end
        checks++;
        if (wr_log.size() != 2 || rdm(32'h40) !== 8'h44 || rdm(32'h41) !== 8'h33
            || rdm(32'h42) !== o2 || rdm(32'h43) !== o3) begin
            errors++;
            $display("FAIL abort_bytes: got %0d writes %h %h %h %h required 2 44 33 %h %h",
                     wr_log.size(), rdm(32'h40), rdm(32'h41), rdm(32'h42), rdm(32'h43), o2, o3);
        end
        checks++;
        if (rd_log.size() != n + 2) begin
            errors++;
            $display("FAIL reprime_count: got %0d reads required 2", rd_log.size() - n);
        end else if (rd_log[n].addr !== 32'd1 || rd_log[n].cyc != r
                     || rd_log[n+1].addr !== 32'd2 || rd_log[n+1].cyc != r + 2) begin
            errors++;
            $display("FAIL reprime: got %h@%0d %h@%0d required 1@%0d 2@%0d",
                     rd_log[n].addr, rd_log[n].cyc, rd_log[n+1].addr, rd_log[n+1].cyc, r, r + 2);
        end
        exp_q.push_back('{1'b1, {o3, o2, 8'h33, 8'h44}, 9});
        run_req(1'b1, 1'b0, 32'h40, 2'd2, 32'h0, got, a, c0);
        e = exp_q.pop_front();
        checks++;
        if (!got || a.rdata !== e.rdata || a.cyc != c0 + e.cyc) begin
            errors++;
            $display("FAIL post_reset_read: got ok=%b data=%h cyc=%0d required %h cyc %0d",
                     got, a.rdata, a.cyc, e.rdata, c0 + e.cyc);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (prot_err != 0) begin
            errors++;
            $display("FAIL ready_missing: got %0d reads without ready required 0", prot_err);
        end
        checks++;
        if (both_err != 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d cycles required 0", both_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_shadow_hit();
        test_arbitration();
        test_wrap();
        test_reset_mid_write();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
